// File: rtl/ahb_ap_ctrl_if.sv
// rtl/ahb_ap_ctrl_if.sv - command/response FIFO and generic bus signals of ahb_ap_ctrl
// master: the controller side; slave: the FIFOs, bus and error monitor around it.
interface ahb_ap_ctrl_if;
  logic        rempty;
  logic [40:0] rdata_fifo1;
  logic        rinc;
  logic        wfull;
  logic [31:0] wdata_fifo2;
  logic        winc;
  logic        busy;
  logic [31:0] rdata_aft;
  logic        ren;
  logic        wen;
  logic [31:0] addr_aft;
  logic [31:0] wdata_aft;
  logic [3:0]  byte_en;
  logic        timeout_err;

  modport master (
    input  rempty, rdata_fifo1, wfull, busy, rdata_aft,
    output rinc, wdata_fifo2, winc, ren, wen, addr_aft, wdata_aft, byte_en, timeout_err
  );

  modport slave (
    output rempty, rdata_fifo1, wfull, busy, rdata_aft,
    input  rinc, wdata_fifo2, winc, ren, wen, addr_aft, wdata_aft, byte_en, timeout_err
  );
endinterface

// File: rtl/ahb_ap_ctrl.sv
// rtl/ahb_ap_ctrl.sv - command-FIFO driven bus access port with timeout and read responses
// Optional: define AHB_AP_AUTOINC_EN to post-increment the address by 4 after each bus access.
module ahb_ap_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ahb_ap_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_BUS = 2'd1,
    RD_BUS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0]  OP_SET_ADDR = 2'b00;
  localparam logic [1:0]  OP_WRITE    = 2'b01;
  localparam logic [1:0]  OP_READ     = 2'b10;
  localparam logic [1:0]  OP_CLR_ERR  = 2'b11;
  localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] ABORT_WORD  = 32'hDEAD_BEEF;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] resp_q, resp_d;
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;

  logic        pop;
  logic        push;
  logic        rd_req;
  logic        wr_req;
  logic [1:0]  opcode;
  logic [31:0] cmd_word;
  logic [3:0]  cmd_be;
  logic        wait_expired;
  logic [31:0] addr_after_xfer;
  logic        unused_cmd_bits;

  assign opcode          = bus.rdata_fifo1[40:39];
  assign cmd_be          = bus.rdata_fifo1[35:32];
  assign cmd_word        = bus.rdata_fifo1[31:0];
  assign unused_cmd_bits = ^bus.rdata_fifo1[38:36];
  assign wait_expired    = (wait_q == WAIT_LAST);

`ifdef AHB_AP_AUTOINC_EN
  assign addr_after_xfer = addr_q + 32'd4;
`else
  assign addr_after_xfer = addr_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      resp_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      resp_q  <= resp_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    resp_d  = resp_q;
    wait_d  = wait_q;
    err_d   = err_q;
    pop     = 1'b0;
    push    = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.rempty) begin
          pop = 1'b1;
          unique case (opcode)
            OP_SET_ADDR: addr_d = cmd_word;
            OP_WRITE: begin
              wdata_d = cmd_word;
              be_d    = cmd_be;
              wait_d  = '0;
              state_d = WR_BUS;
            end
            OP_READ: begin
              be_d    = cmd_be;
              wait_d  = '0;
              state_d = RD_BUS;
            end
            OP_CLR_ERR: err_d = 1'b0;
            default: ;
          endcase
        end
      end

      WR_BUS: begin
        wr_req = 1'b1;
        if (!bus.busy) begin
          addr_d  = addr_after_xfer;
          state_d = IDLE;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          addr_d  = addr_after_xfer;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      RD_BUS: begin
        rd_req = 1'b1;
        // An aborted read still owes the requester exactly one response word.
        if (!bus.busy) begin
          resp_d  = bus.rdata_aft;
          addr_d  = addr_after_xfer;
          state_d = RESP;
        end else if (wait_expired) begin
          resp_d  = ABORT_WORD;
          err_d   = 1'b1;
          addr_d  = addr_after_xfer;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      RESP: begin
        if (!bus.wfull) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked by reset so nothing reaches the FIFOs while it is held.
  assign bus.rinc        = pop & ~rst_i;
  assign bus.winc        = push & ~rst_i;
  assign bus.ren         = rd_req;
  assign bus.wen         = wr_req;
  assign bus.addr_aft    = addr_q;
  assign bus.wdata_aft   = wdata_q;
  assign bus.byte_en     = be_q;
  assign bus.wdata_fifo2 = resp_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_ahb_ap_ctrl.sv
// tb/tb_ahb_ap_ctrl.sv - table-driven self-checking bench for ahb_ap_ctrl (TIMEOUT_CYCLES=4)
module tb_ahb_ap_ctrl;

`ifdef AHB_AP_AUTOINC_EN
  localparam bit AINC = 1'b1;
`else
  localparam bit AINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ahb_ap_ctrl_if bus_if ();

  ahb_ap_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [40:0] cmd;
    int          busy_n;
    int          wfull_n;
    logic [31:0] rdata;
    int          exp_wen;
    int          exp_ren;
    int          exp_winc;
    logic [31:0] exp_resp;
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [40:0] mk_cmd(input logic [1:0] op, input logic [3:0] be,
                                         input logic [31:0] data);
    return {op, 3'b000, be, data};
  endfunction

  function automatic vec_t mkv(input logic [40:0] cmd, input int busy_n, input int wfull_n,
                               input logic [31:0] rdata, input int wn, input int rn,
                               input int wc, input logic [31:0] resp,
                               input logic [31:0] addr, input logic err);
    vec_t v;
    v.cmd = cmd;       v.busy_n = busy_n; v.wfull_n = wfull_n; v.rdata = rdata;
    v.exp_wen = wn;    v.exp_ren = rn;    v.exp_winc = wc;     v.exp_resp = resp;
    v.exp_addr = addr; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0]  op;
    logic        bus_act, seen_bus, done;
    int          bus_cnt, post, wen_n, ren_n, winc_n, rinc_bad, hold_bad;
    logic [31:0] resp;
    op = v.cmd[40:39];
    seen_bus = 0; done = 0; bus_cnt = 0; post = 0;
    wen_n = 0; ren_n = 0; winc_n = 0; rinc_bad = 0; hold_bad = 0; resp = '0;

    @(negedge clk);
    bus_if.rempty      = 1'b0;
    bus_if.rdata_fifo1 = v.cmd;
    bus_if.busy        = 1'b0;
    bus_if.wfull       = 1'b0;
    #1 chk($sformatf("v%0d_pop", idx), 32'(bus_if.rinc), 32'd1);

    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      bus_act          = bus_if.ren | bus_if.wen;
      bus_if.busy      = bus_act && (bus_cnt < v.busy_n);
      bus_if.rdata_aft = v.rdata;
      bus_if.wfull     = !bus_act && seen_bus && (op == 2'b10) && (post < v.wfull_n);
      // Keep a command visible whenever the controller must not pop.
      bus_if.rempty    = !(bus_act || (seen_bus && op == 2'b10 && winc_n == 0));
      #1;
      if (bus_act) begin
        seen_bus = 1;
        bus_cnt++;
        if (bus_if.wen) wen_n++;
        if (bus_if.ren) ren_n++;
        if (bus_if.addr_aft !== v.exp_addr || bus_if.byte_en !== v.cmd[35:32] ||
            (op == 2'b01 && bus_if.wdata_aft !== v.cmd[31:0]))
          hold_bad++;
      end else if (seen_bus) begin
        post++;
      end
      if (bus_if.winc) begin
        winc_n++;
        resp = bus_if.wdata_fifo2;
      end
      if (bus_if.rinc) rinc_bad++;
      if (op == 2'b10)      done = (winc_n > 0);
      else if (op == 2'b01) done = seen_bus && !bus_act;
      else                  done = 1;
    end

    chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_wen_cycles", idx), 32'(wen_n), 32'(v.exp_wen));
    chk($sformatf("v%0d_ren_cycles", idx), 32'(ren_n), 32'(v.exp_ren));
    chk($sformatf("v%0d_winc_count", idx), 32'(winc_n), 32'(v.exp_winc));
    chk($sformatf("v%0d_rinc_nonidle", idx), 32'(rinc_bad), 32'd0);
    chk($sformatf("v%0d_timeout_err", idx), 32'(bus_if.timeout_err), 32'(v.exp_err));
    if (op == 2'b10) chk($sformatf("v%0d_resp", idx), resp, v.exp_resp);
    if (op == 2'b00 || op == 2'b11) chk($sformatf("v%0d_addr", idx), bus_if.addr_aft, v.exp_addr);
    else chk($sformatf("v%0d_bus_hold", idx), 32'(hold_bad), 32'd0);
    bus_if.rempty = 1'b1;
    bus_if.busy   = 1'b0;
    bus_if.wfull  = 1'b0;
  endtask

  initial begin
    int n_rinc, n_wen, n_strobe;

    bus_if.rempty      = 1'b1;
    bus_if.rdata_fifo1 = '0;
    bus_if.wfull       = 1'b0;
    bus_if.busy        = 1'b0;
    bus_if.rdata_aft   = '0;

    vecs[0]  = mkv(mk_cmd(2'b00, 4'h0, 32'h0000_1000), 0, 0, 32'h0, 0, 0, 0, 32'h0,
                   32'h0000_1000, 1'b0);
    vecs[1]  = mkv(mk_cmd(2'b01, 4'hF, 32'hA5A5_A5A5), 0, 0, 32'h0, 1, 0, 0, 32'h0,
                   32'h0000_1000, 1'b0);
    vecs[2]  = mkv(mk_cmd(2'b00, 4'h0, 32'h0000_2000), 0, 0, 32'h0, 0, 0, 0, 32'h0,
                   32'h0000_2000, 1'b0);
    vecs[3]  = mkv(mk_cmd(2'b10, 4'h3, 32'h0), 3, 0, 32'h1234_5678, 0, 4, 1, 32'h1234_5678,
                   32'h0000_2000, 1'b0);
    vecs[4]  = mkv(mk_cmd(2'b10, 4'hF, 32'h0), 0, 5, 32'hCAFE_F00D, 0, 1, 1, 32'hCAFE_F00D,
                   AINC ? 32'h0000_2004 : 32'h0000_2000, 1'b0);
    vecs[5]  = mkv(mk_cmd(2'b10, 4'hC, 32'h0), 100, 0, 32'h5555_5555, 0, 4, 1, 32'hDEAD_BEEF,
                   AINC ? 32'h0000_2008 : 32'h0000_2000, 1'b1);
    vecs[6]  = mkv(mk_cmd(2'b01, 4'h5, 32'h1122_3344), 100, 0, 32'h0, 4, 0, 0, 32'h0,
                   AINC ? 32'h0000_200C : 32'h0000_2000, 1'b1);
    vecs[7]  = mkv(mk_cmd(2'b11, 4'h0, 32'h0), 0, 0, 32'h0, 0, 0, 0, 32'h0,
                   AINC ? 32'h0000_2010 : 32'h0000_2000, 1'b0);
    vecs[8]  = mkv(mk_cmd(2'b00, 4'h0, 32'hFFFF_FFFC), 0, 0, 32'h0, 0, 0, 0, 32'h0,
                   32'hFFFF_FFFC, 1'b0);
    vecs[9]  = mkv(mk_cmd(2'b01, 4'hF, 32'h0000_0000), 0, 0, 32'h0, 1, 0, 0, 32'h0,
                   32'hFFFF_FFFC, 1'b0);
    vecs[10] = mkv(mk_cmd(2'b01, 4'h3, 32'h0F0F_0F0F), 0, 0, 32'h0, 1, 0, 0, 32'h0,
                   AINC ? 32'h0000_0000 : 32'hFFFF_FFFC, 1'b0);
    vecs[11] = mkv(mk_cmd(2'b01, 4'h0, 32'h8765_4321), 3, 0, 32'h0, 4, 0, 0, 32'h0,
                   AINC ? 32'h0000_0004 : 32'hFFFF_FFFC, 1'b0);
    vecs[12] = mkv(mk_cmd(2'b10, 4'h9, 32'h0), 100, 0, 32'h0BAD_0BAD, 0, 4, 1, 32'hDEAD_BEEF,
                   AINC ? 32'h0000_0008 : 32'hFFFF_FFFC, 1'b1);

    #2;
    chk("rst_rinc", 32'(bus_if.rinc), 32'd0);
    chk("rst_winc", 32'(bus_if.winc), 32'd0);
    chk("rst_ren_wen", 32'({bus_if.ren, bus_if.wen}), 32'd0);
    chk("rst_err", 32'(bus_if.timeout_err), 32'd0);
    chk("rst_addr", bus_if.addr_aft, 32'h0);
    chk("rst_wdata", bus_if.wdata_aft, 32'h0);
    chk("rst_resp", bus_if.wdata_fifo2, 32'h0);
    chk("rst_be", 32'(bus_if.byte_en), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a read: ren must drop without waiting for a clock edge.
    @(negedge clk);
    bus_if.rempty      = 1'b0;
    bus_if.rdata_fifo1 = mk_cmd(2'b10, 4'hF, 32'h0);
    bus_if.busy        = 1'b1;
    @(negedge clk);
    bus_if.rempty = 1'b1;
    #1 chk("mid_ren_before_rst", 32'(bus_if.ren), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_ren_in_rst", 32'(bus_if.ren), 32'd0);
    chk("mid_winc_in_rst", 32'(bus_if.winc), 32'd0);
    bus_if.rempty = 1'b0;
    #1 chk("mid_rinc_in_rst", 32'(bus_if.rinc), 32'd0);
    repeat (2) @(negedge clk);
    bus_if.rempty = 1'b1;
    bus_if.busy   = 1'b0;
    rst = 1'b0;
    n_strobe = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_strobe += int'(bus_if.rinc) + int'(bus_if.winc) + int'(bus_if.ren) + int'(bus_if.wen);
      @(negedge clk);
    end
    chk("post_rst_strobes", 32'(n_strobe), 32'd0);
    chk("post_rst_err", 32'(bus_if.timeout_err), 32'd0);
    chk("post_rst_resp", bus_if.wdata_fifo2, 32'h0);
    chk("post_rst_addr", bus_if.addr_aft, 32'h0);

    // Back-to-back writes with a ready bus: one write every two cycles.
    bus_if.rempty      = 1'b0;
    bus_if.rdata_fifo1 = mk_cmd(2'b01, 4'hF, 32'h1357_9BDF);
    n_rinc = 0;
    n_wen  = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_rinc += int'(bus_if.rinc);
      n_wen  += int'(bus_if.wen);
      @(negedge clk);
    end
    bus_if.rempty = 1'b1;
    chk("b2b_rinc", 32'(n_rinc), 32'd4);
    chk("b2b_wen", 32'(n_wen), 32'd4);
    chk("b2b_wdata", bus_if.wdata_aft, 32'h1357_9BDF);
    @(negedge clk);
    #1 chk("b2b_idle", 32'({bus_if.ren, bus_if.wen}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_ap_ctrl.md
AHB_AP_CTRL -- requirements
Module: ahb_ap_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, max bus-wait cycles before an access is aborted (range 2..65535).
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  reset; asynchronous, active-high.
REQ-004 rempty  in  1  command FIFO empty.
REQ-005 rdata_fifo1  in  41  command FIFO head word; first-word-fall-through, valid while rempty=0.
REQ-006 rinc  out  1  command FIFO pop strobe; one cycle per command.
REQ-007 wfull  in  1  response FIFO full.
REQ-008 wdata_fifo2  out  32  response word.
REQ-009 winc  out  1  response FIFO push strobe.
REQ-010 busy  in  1  generic bus not ready; transfer completes in a cycle with ren|wen=1 and busy=0.
REQ-011 rdata_aft  in  32  bus read data; valid in the completing cycle.
REQ-012 ren / wen  out  1 each  bus read / write request; never both high.
REQ-013 addr_aft  out  32  bus address.
REQ-014 wdata_aft  out  32  bus write data.
REQ-015 byte_en  out  4  bus byte lanes.
REQ-016 timeout_err  out  1  sticky bus-timeout flag.

Function
REQ-017 Command decode: opcode=rdata_fifo1[40:39]; 00 SET_ADDR (addr reg<=[31:0]); 01 WRITE (wdata=[31:0], byte_en=[35:32]); 10 READ (byte_en=[35:32]); 11 CLR_ERR (timeout_err<=0).
REQ-018 FSM states: IDLE, WR_BUS, RD_BUS, RESP.
REQ-019 IDLE, rempty=0: rinc=1 that cycle; command latched; SET_ADDR/CLR_ERR take effect next edge and FSM stays IDLE; WRITE->WR_BUS; READ->RD_BUS.
REQ-020 IDLE, rempty=1: rinc=0, no state change.
REQ-021 WR_BUS/RD_BUS: wen/ren=1 with addr_aft, wdata_aft, byte_en held stable until completion or abort.
REQ-022 Completion (busy=0): WR_BUS->IDLE; RD_BUS captures rdata_aft into response reg, ->RESP.
REQ-023 Wait counter clears on entering a bus state, increments each busy=1 cycle; at count TIMEOUT_CYCLES-1 with busy=1: abort, set timeout_err; WR_BUS->IDLE; RD_BUS loads 0xDEADBEEF into response reg, ->RESP.
REQ-024 RESP: wdata_fifo2=response reg; winc=1 only while wfull=0, then ->IDLE; wfull=1 holds RESP with winc=0, indefinitely.
REQ-025 Latency: read popped at edge N -> ren high cycle N+1; busy=0 in N+1 -> winc in N+2 -> IDLE at N+3; back-to-back writes with busy=0 issue one every 2 cycles.
REQ-026 Exactly one response word per READ (including aborted); none for other opcodes.
REQ-027 SET_ADDR and CLR_ERR in the same IDLE cycle as timeout set: CLR_ERR executes only when dequeued; a timeout in progress cannot coincide (FSM not IDLE).
REQ-028 rinc never asserted outside IDLE; winc never outside RESP.

Reset
REQ-029 RST=1 asynchronously forces IDLE; rinc, winc, ren, wen, timeout_err=0; addr_aft, wdata_aft, wdata_fifo2, byte_en, wait counter, response reg=0.
REQ-030 Reset mid-transfer drops ren/wen immediately; pending response discarded; no FIFO strobe until a new command after RST falls.

Configuration
REQ-031 Macro AHB_AP_AUTOINC_EN defined: addr reg += 4 (mod 2^32, 0xFFFFFFFC wraps to 0) on each completed or aborted WRITE/READ; undefined: addr reg changes only on SET_ADDR.

Verification
REQ-032 SET_ADDR 0x1000, WRITE 0xA5A5A5A5 be=0xF, busy=0 -> one wen cycle, addr_aft=0x1000, wdata_aft=0xA5A5A5A5, no winc.
REQ-033 SET_ADDR 0x2000, READ, busy=1 for 3 cycles, rdata_aft=0x12345678 -> ren held 4 cycles, one winc with 0x12345678.
REQ-034 READ with wfull=1 for 5 cycles after completion -> winc=0 during those cycles, single winc once wfull=0, rinc=0 throughout.
REQ-035 TIMEOUT_CYCLES=4, READ, busy stuck 1 -> ren drops after 4 cycles, winc with 0xDEADBEEF, timeout_err=1; CLR_ERR -> timeout_err=0.
REQ-036 AHB_AP_AUTOINC_EN, SET_ADDR 0xFFFFFFFC, two WRITEs -> addr_aft 0xFFFFFFFC then 0x00000000; without macro both 0xFFFFFFFC.
REQ-037 RST asserted while ren=1 -> ren=0 same cycle, no winc, FSM IDLE after release.
